cnn_stage_sequencer: RTL

Parametrised controller that sequences the CNN pattern-detection pipeline through `NUM_STAGES` compute stages with per-stage start/done handshakes. It reports the active stage and overall completion, and arbitrates the result-memory read port for the display path once processing is complete. It sits between the top-level `go`/`done` control and the stage engines. It generalises the fixed five-stage flow with:

- a configurable stage count;
- a per-stage watchdog timeout;
- a continuous (repeat) mode;
- a registered display read path.

---
 rtl/cnn_pkg.sv | 18 +
 rtl/stage_watchdog.sv | 41 ++++
 rtl/cnn_stage_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared state encoding and default widths for the CNN stage sequencer.
package cnn_pkg;

    localparam int CNN_NUM_STAGES = 5;
    localparam int CNN_ADDR_W     = 17;
    localparam int CNN_DATA_W     = 1;
    localparam int CNN_TIMEOUT_W  = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_ADVANCE,
        S_DONE,
        S_ERROR
    } seq_state_e;

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage watchdog: loadable up-counter with clear, enable and a
// saturate flag that stays up once the counter reaches all-ones.
module stage_watchdog
    import cnn_pkg::*;
#(
    parameter int TIMEOUT_W = CNN_TIMEOUT_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic                 load_i,
    input  logic [TIMEOUT_W-1:0] load_val_i,
    output logic                 sat_o
);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;

    assign sat_o = &cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && !sat_o) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cnn_stage_sequencer.sv
// Sequences the CNN pipeline stages with start/done handshakes, a
// per-stage watchdog and a registered display read path.
module cnn_stage_sequencer
    import cnn_pkg::*;
#(
    parameter int NUM_STAGES = CNN_NUM_STAGES,
    parameter int ADDR_W     = CNN_ADDR_W,
    parameter int DATA_W     = CNN_DATA_W,
    parameter int TIMEOUT_W  = CNN_TIMEOUT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic                  repeat_en,
    output logic [NUM_STAGES-1:0] stage_start,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_active,
    output logic                  done,
    output logic                  pass_done,
    output logic                  timeout,
    input  logic                  ena_display,
    input  logic                  read_display,
    input  logic [ADDR_W-1:0]     addr_display,
    output logic                  mem_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_dout,
    output logic [DATA_W-1:0]     dout_display,
    output logic                  display_valid
);

    localparam int IDX_W =
        (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX =
        IDX_W'(NUM_STAGES - 1);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             go_arm_q;
    logic             go_edge;
    logic             wd_clr;
    logic             wd_en;
    logic             wd_sat;
    logic             rd_q;
    logic             valid_q;
    logic [DATA_W-1:0] dout_q;

    // Armed only after go has been seen low, so a go held
    // high through reset cannot start a run.
    assign go_edge = go & go_arm_q;

    stage_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (wd_clr),
        .en_i       (wd_en),
        .load_i     (1'b0),
        .load_val_i ('0),
        .sat_o      (wd_sat)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wd_clr       = 1'b0;
        wd_en        = 1'b0;
        stage_start  = '0;
        stage_active = '0;
        pass_done    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (go_edge) begin
                    state_d = S_LAUNCH;
                    idx_d   = '0;
                end
            end
            S_LAUNCH: begin
                stage_start[idx_q] = 1'b1;
                wd_clr             = 1'b1;
                state_d            = S_RUN;
            end
            S_RUN: begin
                stage_active[idx_q] = 1'b1;
                wd_en               = 1'b1;
                // A completing stage beats a same-cycle timeout.
                if (stage_done[idx_q]) begin
                    state_d = S_ADVANCE;
                end else if (wd_sat) begin
                    state_d = S_ERROR;
                end
            end
            S_ADVANCE: begin
                if (idx_q != LAST_IDX) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_LAUNCH;
                end else begin
                    pass_done = 1'b1;
                    if (repeat_en) begin
                        idx_d   = '0;
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign done    = (state_q == S_DONE);
    assign timeout = (state_q == S_ERROR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            go_arm_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            go_arm_q <= ~go;
        end
    end

    assign mem_en = ena_display & read_display
                  & (state_q == S_DONE);
    assign mem_addr = addr_display;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            rd_q    <= mem_en;
            valid_q <= rd_q;
            if (rd_q) begin
                dout_q <= mem_dout;
            end
        end
    end

    assign dout_display  = dout_q;
    assign display_valid = valid_q;

endmodule
